// File: rtl/key_event_gen_pkg.sv
// Shared definitions for the key event generator: FSM state encoding and sizing helpers.
// The state codes are also decoded by the keyboard port, so their values are fixed.
package key_event_gen_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DELAY  = 2'd1,
    ST_REPEAT = 2'd2
  } kev_state_e;

  function automatic int kev_max(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  // Counter width; never below 1 bit so tiny tick values still elaborate.
  function automatic int kev_cnt_w(input int delay_ticks, input int repeat_ticks);
    int m;
    m = kev_max(delay_ticks, repeat_ticks);
    return (m > 1) ? $clog2(m) : 1;
  endfunction

endpackage

// File: rtl/key_event_gen_lowest_set_encoder.sv
// Combinational lowest-set-bit encoder: index of the lowest asserted bit plus an any-set flag.
module lowest_set_encoder #(
  parameter int N     = 8,
  parameter int IDX_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]     vec_i,
  output logic [IDX_W-1:0] idx_o,
  output logic             any_o
);

  // Scan high to low so the lowest set bit writes last and wins.
  always_comb begin
    idx_o = '0;
    any_o = 1'b0;
    for (int i = N - 1; i >= 0; i--) begin
      if (vec_i[i]) begin
        idx_o = IDX_W'(i);
        any_o = 1'b1;
      end
    end
  end

endmodule

// File: rtl/key_event_gen.sv
// Turns debounced key levels into press / typematic-repeat key-code events behind a
// one-entry valid/ready holding register; events that find it full are dropped and flagged.
module key_event_gen
  import key_event_gen_pkg::*;
#(
  parameter int NUM_KEYS     = 8,
  parameter int DELAY_TICKS  = 500000,
  parameter int REPEAT_TICKS = 50000,
  parameter bit REPEAT_EN    = 1'b1
) (
  input  logic                        i_clk,
  input  logic                        i_rst_n,
  input  logic [NUM_KEYS-1:0]         i_keys,
  output logic                        o_valid,
  output logic [$clog2(NUM_KEYS)-1:0] o_code,
  output logic                        o_repeat,
  input  logic                        i_ready,
  output logic                        o_overrun
);

  localparam int IDX_W = $clog2(NUM_KEYS);
  localparam int CNT_W = kev_cnt_w(DELAY_TICKS, REPEAT_TICKS);
  localparam logic [CNT_W-1:0] DLY_LAST = CNT_W'(DELAY_TICKS - 1);
  localparam logic [CNT_W-1:0] RPT_LAST = CNT_W'(REPEAT_TICKS - 1);

  logic [NUM_KEYS-1:0] prev_q;
  logic [NUM_KEYS-1:0] rise;
  logic [IDX_W-1:0]    rise_idx;
  logic                rise_any;

  kev_state_e          state_q, state_d;
  logic [IDX_W-1:0]    key_q, key_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;

  logic                emit;
  logic                emit_rep;
  logic [IDX_W-1:0]    emit_code;

  logic                valid_q, valid_d;
  logic [IDX_W-1:0]    code_q, code_d;
  logic                rep_q, rep_d;
  logic                ovr_q, ovr_d;
  logic                can_load;

  assign rise = i_keys & ~prev_q;

  lowest_set_encoder #(.N(NUM_KEYS), .IDX_W(IDX_W)) u_enc (
    .vec_i (rise),
    .idx_o (rise_idx),
    .any_o (rise_any)
  );

  // Tracking FSM: a new press always wins; otherwise time the held key.
  always_comb begin
    state_d   = state_q;
    key_d     = key_q;
    cnt_d     = cnt_q;
    emit      = 1'b0;
    emit_rep  = 1'b0;
    emit_code = key_q;
    if (rise_any) begin
      key_d     = rise_idx;
      state_d   = ST_DELAY;
      cnt_d     = '0;
      emit      = 1'b1;
      emit_code = rise_idx;
    end else begin
      unique case (state_q)
        ST_DELAY, ST_REPEAT: begin
          if (!i_keys[key_q]) begin
            state_d = ST_IDLE;
            cnt_d   = '0;
          end else if (REPEAT_EN &&
                       (cnt_q == ((state_q == ST_DELAY) ? DLY_LAST : RPT_LAST))) begin
            state_d  = ST_REPEAT;
            cnt_d    = '0;
            emit     = 1'b1;
            emit_rep = 1'b1;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        default: begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end
      endcase
    end
  end

  // Holding register: load when empty or draining this cycle, else drop and flag.
  assign can_load = !valid_q || i_ready;

  always_comb begin
    valid_d = valid_q;
    code_d  = code_q;
    rep_d   = rep_q;
    ovr_d   = 1'b0;
    if (emit) begin
      if (can_load) begin
        valid_d = 1'b1;
        code_d  = emit_code;
        rep_d   = emit_rep;
      end else begin
        ovr_d = 1'b1;
      end
    end else if (valid_q && i_ready) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      prev_q  <= '0;
      state_q <= ST_IDLE;
      key_q   <= '0;
      cnt_q   <= '0;
      valid_q <= 1'b0;
      code_q  <= '0;
      rep_q   <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      prev_q  <= i_keys;
      state_q <= state_d;
      key_q   <= key_d;
      cnt_q   <= cnt_d;
      valid_q <= valid_d;
      code_q  <= code_d;
      rep_q   <= rep_d;
      ovr_q   <= ovr_d;
    end
  end

  assign o_valid   = valid_q;
  assign o_code    = code_q;
  assign o_repeat  = rep_q;
  assign o_overrun = ovr_q;

endmodule
